// File: rtl/uart_cond_pkg.sv
// Shared constants and helpers for the UART line conditioner.
package uart_cond_pkg;

    // Idle (mark) level of a UART line.
    localparam logic UART_IDLE = 1'b1;

    // Converts a hold time in milliseconds to clock cycles.
    function automatic int ms_to_cycles(input int freq, input int ms);
        return freq / 1000 * ms;
    endfunction

    // Bits needed to hold the values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_line_conditioner_stretcher.sv
// Activity stretcher: a falling edge on 'line' lights 'led' for HOLD cycles,
// and any later falling edge restarts the full hold time.
module activity_stretcher
    import uart_cond_pkg::*;
#(
    parameter int HOLD = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic led
);

    localparam int            CW       = cnt_width(HOLD);
    localparam logic [CW-1:0] HOLD_VAL = CW'(HOLD);

    logic          prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          led_q, led_d;
    logic          fall;

    // Edge detect and reload/countdown; an edge wins over the countdown so a
    // retrigger on the last hold cycle leaves no gap in the LED.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        fall   = prev_q & ~line;
        prev_d = line;
        cnt_d  = cnt_q;
        if (fall) begin
            cnt_d = HOLD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
        led_d = (cnt_q != '0);
    end

    // State registers; reset parks the line history at idle so release cannot
    // look like a falling edge.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values,
        // independent of statement order.
        if (rst) begin
            prev_q <= UART_IDLE;
            cnt_q  <= '0;
            led_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
            led_q  <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/uart_line_conditioner.sv
// UART pin conditioner: RX synchronizer + glitch filter, registered TX,
// stretched activity LEDs and an optional line-break detector.
// Build option: define UART_LINE_COND_BREAK_EN to include the break detector;
// otherwise rx_break is tied low and BREAK_CYCLES is unused.
module uart_line_conditioner
    import uart_cond_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int FILTER_LEN   = 4,
    parameter int LED_HOLD_MS  = 20,
    parameter int BREAK_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_pin,
    output logic rx_clean,
    input  logic tx_core,
    output logic tx_pin,
    output logic rx_led,
    output logic tx_led,
    output logic rx_break
);

    localparam int            HOLD  = ms_to_cycles(CLK_FREQ, LED_HOLD_MS);
    localparam int            FW    = cnt_width(FILTER_LEN);
    localparam logic [FW-1:0] FLAST = FW'(FILTER_LEN - 1);

    if (FILTER_LEN < 1 || BREAK_CYCLES < 1) begin : g_param_check
        $error("uart_line_conditioner: FILTER_LEN and BREAK_CYCLES must be >= 1");
    end

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          rx_clean_q, rx_clean_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          tx_pin_q, tx_pin_d;

    // Synchronizer shift, glitch filter and TX register next-state.
    always_comb begin
        s1_d       = rx_pin;
        s2_d       = s1_q;
        rx_clean_d = rx_clean_q;
        fcnt_d     = '0;
        if (s2_q != rx_clean_q) begin
            if (fcnt_q == FLAST) begin
                rx_clean_d = s2_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
        tx_pin_d = tx_core;
    end

    // Line registers; everything returns to the idle (mark) level on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= UART_IDLE;
            s2_q       <= UART_IDLE;
            rx_clean_q <= UART_IDLE;
            fcnt_q     <= '0;
            tx_pin_q   <= UART_IDLE;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            rx_clean_q <= rx_clean_d;
            fcnt_q     <= fcnt_d;
            tx_pin_q   <= tx_pin_d;
        end
    end

    assign rx_clean = rx_clean_q;
    assign tx_pin   = tx_pin_q;

    activity_stretcher #(.HOLD(HOLD)) u_rx_activity (
        .clk  (clk),
        .rst  (rst),
        .line (rx_clean_q),
        .led  (rx_led)
    );

    activity_stretcher #(.HOLD(HOLD)) u_tx_activity (
        .clk  (clk),
        .rst  (rst),
        .line (tx_pin_q),
        .led  (tx_led)
    );

`ifdef UART_LINE_COND_BREAK_EN
    localparam int            BW   = cnt_width(BREAK_CYCLES);
    localparam logic [BW-1:0] BMAX = BW'(BREAK_CYCLES);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          rx_break_q, rx_break_d;

    // Saturating count of consecutive low cycles on the filtered line.
    always_comb begin
        bcnt_d = '0;
        if (!rx_clean_q) begin
            bcnt_d = (bcnt_q == BMAX) ? bcnt_q : bcnt_q + BW'(1);
        end
        rx_break_d = (bcnt_q == BMAX);
    end

    // Break counter and registered break flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt_q     <= '0;
            rx_break_q <= 1'b0;
        end else begin
            bcnt_q     <= bcnt_d;
            rx_break_q <= rx_break_d;
        end
    end

    assign rx_break = rx_break_q;
`else
    assign rx_break = 1'b0;
`endif

endmodule
